// File: rtl/conv_pkg.sv
// Shared defaults and elaboration-time helpers for the convolution accumulation tree.
package conv_pkg;

    localparam int NUM_IN_DEF    = 8;
    localparam int IN_W_DEF      = 19;
    localparam int ACC_EXTRA_DEF = 4;

    function automatic int clog2i(input int n);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic int out_width(input int in_w, input int num_in, input int acc_extra);
        return in_w + clog2i(num_in) + acc_extra;
    endfunction

    // Bit offset of tree level lvl inside the flat level bus; level j holds
    // num_in>>j lanes of in_w+j bits each.
    function automatic int bus_off(input int num_in, input int in_w, input int lvl);
        int off = 0;
        for (int j = 0; j < lvl; j++)
            off += (num_in >> j) * (in_w + j);
        return off;
    endfunction

endpackage

// File: rtl/tree_add_stage.sv
// One registered adder lane of the reduction tree: W-bit signed pair in, W+1-bit sum out.
module tree_add_stage #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_i,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         vld_o,
    output logic [W:0]   sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_o <= 1'b0;
            sum   <= '0;
        end else begin
            vld_o <= vld_i;
            if (vld_i)
                sum <= {a[W-1], a} + {b[W-1], b};
        end
    end

endmodule

// File: rtl/conv_acc_tree.sv
// Pipelined binary adder tree over NUM_IN signed channels feeding a saturating
// multi-beat group accumulator.
module conv_acc_tree
    import conv_pkg::*;
#(
    parameter  int NUM_IN    = NUM_IN_DEF,
    parameter  int IN_W      = IN_W_DEF,
    parameter  int ACC_EXTRA = ACC_EXTRA_DEF,
    localparam int LVL       = clog2i(NUM_IN),
    localparam int OUT_W     = out_width(IN_W, NUM_IN, ACC_EXTRA)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vbit_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic [NUM_IN*IN_W-1:0]   data_i,
    output logic signed [OUT_W-1:0]  data_o,
    output logic                     vbit_o,
    output logic                     sat_o
);

    localparam int TW    = IN_W + LVL;
    localparam int BUS_W = bus_off(NUM_IN, IN_W, LVL + 1);

    logic [BUS_W-1:0] tree_bus;
    logic [LVL:0]     vld_pipe, first_pipe, last_pipe;
    logic [LVL-1:0]   first_q, last_q;

    assign tree_bus[NUM_IN*IN_W-1:0] = data_i;
    assign vld_pipe[0]   = vbit_i;
    assign first_pipe[0] = first_i;
    assign last_pipe[0]  = last_i;

    genvar l, k;
    generate
        for (l = 0; l < LVL; l++) begin : g_lvl
            localparam int W   = IN_W + l;
            localparam int N   = NUM_IN >> (l + 1);
            localparam int SRC = bus_off(NUM_IN, IN_W, l);
            localparam int DST = bus_off(NUM_IN, IN_W, l + 1);
            logic [N-1:0] lane_vld;

            for (k = 0; k < N; k++) begin : g_lane
                tree_add_stage #(.W(W)) u_add (
                    .clk   (clk),
                    .rst   (rst),
                    .vld_i (vld_pipe[l]),
                    .a     (tree_bus[SRC + (2*k)*W   +: W]),
                    .b     (tree_bus[SRC + (2*k+1)*W +: W]),
                    .vld_o (lane_vld[k]),
                    .sum   (tree_bus[DST + k*(W+1) +: W+1])
                );
            end

            // all lanes of a level carry the same valid
            assign vld_pipe[l+1] = |lane_vld;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= '0;
            last_q  <= '0;
        end else begin
            first_q <= first_pipe[LVL-1:0];
            last_q  <= last_pipe[LVL-1:0];
        end
    end

    assign first_pipe[LVL:1] = first_q;
    assign last_pipe[LVL:1]  = last_q;

    logic signed [TW-1:0]    tree_sum;
    logic signed [OUT_W-1:0] acc, acc_base, acc_nxt;
    logic signed [OUT_W:0]   acc_sum;
    logic                    grp_sat, sat_nxt, ovf;

    assign tree_sum = tree_bus[BUS_W-1 -: TW];

    // One guard bit above OUT_W detects overflow; clamp toward the sign of the true sum.
    always_comb begin
        acc_base = first_pipe[LVL] ? '0 : acc;
        acc_sum  = (OUT_W+1)'(acc_base) + (OUT_W+1)'(tree_sum);
        ovf      = acc_sum[OUT_W] != acc_sum[OUT_W-1];
        acc_nxt  = acc_sum[OUT_W-1:0];
        if (ovf)
            acc_nxt = acc_sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        sat_nxt  = (first_pipe[LVL] ? 1'b0 : grp_sat) | ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            grp_sat <= 1'b0;
            data_o  <= '0;
            sat_o   <= 1'b0;
            vbit_o  <= 1'b0;
        end else begin
            vbit_o <= vld_pipe[LVL] & last_pipe[LVL];
            if (vld_pipe[LVL]) begin
                acc     <= acc_nxt;
                grp_sat <= sat_nxt;
                if (last_pipe[LVL]) begin
                    data_o <= acc_nxt;
                    sat_o  <= sat_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_acc_tree.sv
// Self-checking bench for conv_acc_tree: directed vector table, hand-written
// multi-cycle sequences and randomized groups against a queue-based group model.
module tb_conv_acc_tree;

    localparam int NUM_IN = 8;
    localparam int IN_W   = 19;
    localparam int OUT_W  = 26;
    localparam int LAT    = 4;
    localparam longint SMAX = (longint'(1) << (OUT_W-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (OUT_W-1));

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     vbit_i = 1'b0, first_i = 1'b0, last_i = 1'b0;
    logic [NUM_IN*IN_W-1:0]   data_i = '0;
    logic signed [OUT_W-1:0]  data_o;
    logic                     vbit_o, sat_o;

    conv_acc_tree dut (
        .clk     (clk),
        .rst     (rst),
        .vbit_i  (vbit_i),
        .first_i (first_i),
        .last_i  (last_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .vbit_o  (vbit_o),
        .sat_o   (sat_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct { longint data; bit sat; int due; } exp_t;
    exp_t   expq[$];
    longint m_acc = 0;
    bit     m_sat = 1'b0;
    bit     mon_due;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Every pulse, and every cycle a result is due, is compared against the model.
    always @(negedge clk) begin
        if (!rst) begin
            mon_due = expq.size() > 0 && expq[0].due == cyc;
            if (mon_due || vbit_o) begin
                check("vbit_o timing", longint'(vbit_o), longint'(mon_due));
                if (mon_due) begin
                    check("model data_o", longint'(data_o), expq[0].data);
                    check("model sat_o", longint'(sat_o), longint'(expq[0].sat));
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input int vals[NUM_IN], input bit f, input bit l);
        longint s = 0;
        for (int c = 0; c < NUM_IN; c++) begin
            data_i[c*IN_W +: IN_W] = vals[c][IN_W-1:0];
            s += vals[c];
        end
        vbit_i = 1'b1; first_i = f; last_i = l;
        if (f) begin m_acc = 0; m_sat = 1'b0; end
        m_acc += s;
        if (m_acc > SMAX) begin m_acc = SMAX; m_sat = 1'b1; end
        else if (m_acc < SMIN) begin m_acc = SMIN; m_sat = 1'b1; end
        if (l) expq.push_back('{m_acc, m_sat, cyc + LAT});
        @(posedge clk);
        #1;
        vbit_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic fill(input int lo, input int hi, output int v[NUM_IN]);
        for (int c = 0; c < NUM_IN; c++) v[c] = (c < NUM_IN/2) ? lo : hi;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, " data_o"}, longint'(data_o), 0);
        check({tag, " vbit_o"}, longint'(vbit_o), 0);
        check({tag, " sat_o"},  longint'(sat_o), 0);
        expq.delete();
        m_acc = 0; m_sat = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct { int lo; int hi; longint exp_data; bit exp_sat; } vec_t;
    vec_t tbl[7];

    initial begin
        int v[NUM_IN];
        int pulses;

        tbl[0] = '{1000, 1000, 8000, 1'b0};
        tbl[1] = '{262143, -262144, -4, 1'b0};
        tbl[2] = '{1, 1, 8, 1'b0};
        tbl[3] = '{-262144, -262144, -2097152, 1'b0};
        tbl[4] = '{0, 0, 0, 1'b0};
        tbl[5] = '{-1, 3, 8, 1'b0};
        tbl[6] = '{262143, 262143, 2097144, 1'b0};

        #7;
        check("reset data_o", longint'(data_o), 0);
        check("reset vbit_o", longint'(vbit_o), 0);
        check("reset sat_o",  longint'(sat_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single-beat groups: silent for 3 cycles, pulse on the 4th, then hold
        for (int i = 0; i < 7; i++) begin
            fill(tbl[i].lo, tbl[i].hi, v);
            beat(v, 1'b1, 1'b1);
            idle(2);
            check("tbl early vbit_o", longint'(vbit_o), 0);
            idle(1);
            check("tbl vbit_o", longint'(vbit_o), 1);
            check("tbl data_o", longint'(data_o), tbl[i].exp_data);
            check("tbl sat_o",  longint'(sat_o), longint'(tbl[i].exp_sat));
            idle(1);
            check("tbl pulse width", longint'(vbit_o), 0);
            check("tbl hold data_o", longint'(data_o), tbl[i].exp_data);
        end

        async_reset("async reset");

        // 3-beat group with bubbles
        fill(100, 100, v);
        beat(v, 1'b1, 1'b0);
        idle(2);
        beat(v, 1'b0, 1'b0);
        idle(1);
        beat(v, 1'b0, 1'b1);
        idle(2);
        check("grp3 early vbit_o", longint'(vbit_o), 0);
        idle(1);
        check("grp3 vbit_o", longint'(vbit_o), 1);
        check("grp3 data_o", longint'(data_o), 2400);

        // saturation, then a fresh group clears the sticky flag
        fill(262143, 262143, v);
        for (int b = 0; b < 20; b++) beat(v, b == 0, b == 19);
        idle(3);
        check("sat data_o", longint'(data_o), 33554431);
        check("sat sat_o",  longint'(sat_o), 1);
        fill(1, 1, v);
        beat(v, 1'b1, 1'b1);
        idle(3);
        check("post-sat data_o", longint'(data_o), 8);
        check("post-sat sat_o",  longint'(sat_o), 0);

        // reset after beat 2 of a 3-beat group
        fill(7, 7, v);
        beat(v, 1'b1, 1'b0);
        beat(v, 1'b0, 1'b0);
        async_reset("mid-group reset");
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (vbit_o) pulses++;
        end
        check("aborted group pulses", pulses, 0);
        fill(5, 5, v);
        beat(v, 1'b1, 1'b1);
        idle(3);
        check("after reset data_o", longint'(data_o), 40);

        // non-first beat right after reset starts from zero
        async_reset("reset before orphan");
        fill(2, 2, v);
        beat(v, 1'b0, 1'b1);
        idle(3);
        check("orphan beat data_o", longint'(data_o), 16);

        // first inside an open group restarts it
        fill(1, 1, v);
        beat(v, 1'b1, 1'b0);
        beat(v, 1'b1, 1'b0);
        beat(v, 1'b0, 1'b1);
        idle(3);
        check("restart data_o", longint'(data_o), 16);

        // randomized groups against the model
        for (int g = 0; g < 60; g++) begin
            int len;
            len = ($urandom % 8 == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(1, 5));
            for (int b = 0; b < len; b++) begin
                bit f;
                case ($urandom % 4)
                    0: fill(262143, 262143, v);
                    1: fill(-262144, -262144, v);
                    default:
                        for (int c = 0; c < NUM_IN; c++)
                            v[c] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W-1));
                endcase
                f = (b == 0) ? ($urandom % 10 != 0) : ($urandom % 10 == 0);
                beat(v, f, b == len - 1);
                idle($urandom_range(0, 2));
            end
        end

        idle(8);
        check("pending results", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
